mem_port_sequencer: RTL
=======================

# mem_port_sequencer

Sequences the single-ported unified instruction/data memory of the five-stage pipeline. It grants the port each cycle to one of three requesters: instruction fetch, a normal MEM-stage load/store, or a two-access memory-indirect special instruction (LWi, SWi, Add). For the special instructions it runs a small state machine and drives the pipeline freeze/flush controls. It sits between the pipeline registers and the memory, beside the hazard unit.

## Interface
Parameters:
- AW, 32, memory address width
- DW, 32, memory data width

Ports:
- clk  in  1  rising-edge clock
- rest  in  1  reset; synchronous, active-high
- if_addr  in  AW  fetch address (PC)
- if_valid  out  1  fetch granted this cycle; instruction = mem_rdata
- dm_read  in  1  MEM-stage normal load
- dm_write  in  1  MEM-stage normal store
- dm_addr  in  AW  normal load/store address
- dm_wdata  in  DW  normal store data
- sp_op  in  2  special op in MEM: 2=LWi, 1=SWi, 0=Add, 3=none
- sp_addr  in  AW  special op base address
- sp_wdata  in  DW  SWi store data / Add addend
- sp_result  out  DW  registered special op result
- sp_done  out  1  one-cycle pulse; special op complete
- stall_pipe  out  1  freeze IF/ID, ID/EX, EX/MEM, MEM/WB
- freeze_pc  out  1  hold PC
- flush_ifid  out  1  insert bubble into IF/ID
- mem_addr  out  AW  memory address
- mem_we  out  1  memory write enable
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data (combinational read)

## Operation
- The memory performs one access per cycle.
  - Reads are combinational: mem_rdata is valid in the same cycle as mem_addr.
  - Writes commit on the clk edge while mem_we=1.
- States: IDLE, SECOND, DONE. Internal registers: tmp[DW-1:0], sp_result.
- IDLE:
  - sp_op!=3:
    - Port drives mem_addr=sp_addr, mem_we=0. tmp<=mem_rdata.
    - stall_pipe=1, freeze_pc=1, flush_ifid=0.
    - Next state SECOND. dm_read/dm_write are ignored (mutually exclusive by decode; a bench assertion covers it).
  - else dm_read|dm_write:
    - mem_addr=dm_addr, mem_we=dm_write, mem_wdata=dm_wdata.
    - freeze_pc=1, flush_ifid=1 (the fetch is lost), stall_pipe=0, if_valid=0.
  - else (fetch):
    - mem_addr=if_addr, mem_we=0, if_valid=1.
    - All freeze/flush signals 0.
- SECOND: stall_pipe=1, freeze_pc=1. Next state DONE.
  - LWi: read mem[tmp]; sp_result<=mem_rdata.
  - SWi: write mem[tmp]<=sp_wdata; sp_result<=tmp.
  - Add: write mem[sp_addr]<=tmp+sp_wdata, wrapping modulo 2^DW; sp_result<=tmp+sp_wdata.
- DONE:
  - sp_done=1 and stall_pipe=0.
  - The port serves fetch exactly as in IDLE with no data request.
  - sp_op is ignored, because the finished instruction is still visible in MEM this cycle.
  - Next state IDLE.
- mem_wdata=0 whenever mem_we=0.

## Timing
- Reset (rest=1 at an edge):
  - state<=IDLE, tmp<=0, sp_result<=0.
  - Any in-flight special op is abandoned and no write is issued in the reset cycle.
- While rest=1 the combinational outputs are forced to:
  - mem_we=0, stall_pipe=0, freeze_pc=0, flush_ifid=0, sp_done=0
  - mem_addr=if_addr, if_valid=0.
- Special op latency: first presented in cycle N (IDLE), second access in N+1, sp_done and valid sp_result in N+2.
  - stall_pipe is high in N and N+1.
  - The pipeline advances at the end of N+2.
- Normal load/store costs one fetch slot: freeze_pc and flush_ifid are high for one cycle and stall_pipe stays low.
- Back-to-back special ops: the second is accepted in the IDLE cycle following DONE. The minimum spacing is 3 cycles.
- Special op presented in the cycle immediately after DONE: accepted normally.
- rest asserted during SECOND: the state is abandoned at that edge and sp_done never pulses for that op.

## Test plan
- Reset then fetch only: rest=1 one cycle, if_addr=0x40, no requests -> mem_addr=0x40, if_valid=1, all stall/freeze/flush 0, sp_result=0.
- Normal store: dm_write=1, dm_addr=0x100, dm_wdata=0xAA -> same cycle mem_we=1, mem_addr=0x100, freeze_pc=1, flush_ifid=1, stall_pipe=0; next cycle mem[0x100]=0xAA.
- LWi: mem[0x10]=0x20, mem[0x20]=0x1234, sp_op=2, sp_addr=0x10 -> stall_pipe high 2 cycles; sp_done pulse in cycle 3 with sp_result=0x1234; no write.
- SWi then Add back-to-back:
  - SWi: mem[0x10]=0x30, sp_op=1, sp_wdata=0x55 -> mem[0x30]=0x55, sp_result=0x30.
  - Add at IDLE right after DONE: sp_op=0, sp_addr=0x30, sp_wdata=0xFFFFFFFF -> mem[0x30]=0x54 (wrap), sp_result=0x54.
- Reset mid-op: LWi accepted, rest=1 in the SECOND cycle -> no sp_done, state IDLE, sp_result=0, mem_we=0 throughout.

Source files
------------

// File: rtl/mem_port_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_sequencer_if
// Purpose  : Bundles the fetch, MEM-stage, special-op, pipeline-control and
//            unified-memory signals that surround mem_port_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_port_sequencer_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0] if_addr;
    logic          if_valid;
    logic          dm_read;
    logic          dm_write;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [1:0]    sp_op;
    logic [AW-1:0] sp_addr;
    logic [DW-1:0] sp_wdata;
    logic [DW-1:0] sp_result;
    logic          sp_done;
    logic          stall_pipe;
    logic          freeze_pc;
    logic          flush_ifid;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    // The sequencer side: owns the memory port and the pipeline controls.
    modport master (
        input  if_addr, dm_read, dm_write, dm_addr, dm_wdata,
        input  sp_op, sp_addr, sp_wdata, mem_rdata,
        output if_valid, sp_result, sp_done, stall_pipe, freeze_pc,
        output flush_ifid, mem_addr, mem_we, mem_wdata
    );

    // The environment side: pipeline registers plus the memory array.
    modport slave (
        output if_addr, dm_read, dm_write, dm_addr, dm_wdata,
        output sp_op, sp_addr, sp_wdata, mem_rdata,
        input  if_valid, sp_result, sp_done, stall_pipe, freeze_pc,
        input  flush_ifid, mem_addr, mem_we, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_sequencer
// Purpose  : Arbitrates the single unified memory port between fetch, normal
//            loads/stores and two-access memory-indirect ops (LWi/SWi/Add).
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_sequencer #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input wire                    clk,
    input wire                    rest,
    mem_port_sequencer_if.master  bus
);

    localparam logic [1:0] c_OP_ADD  = 2'd0;
    localparam logic [1:0] c_OP_SWI  = 2'd1;
    localparam logic [1:0] c_OP_LWI  = 2'd2;
    localparam logic [1:0] c_OP_NONE = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SECOND = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] tmp_q, tmp_d;
    logic [DW-1:0] sp_result_q, sp_result_d;

    logic [DW-1:0] w_sum;
    logic [AW-1:0] w_mem_addr;
    logic          w_mem_we;
    logic [DW-1:0] w_wdata;
    logic          w_if_valid;
    logic          w_stall;
    logic          w_freeze;
    logic          w_flush;
    logic          w_done;

    assign w_sum = tmp_q + bus.sp_wdata;

    always_comb begin
        state_d     = state_q;
        tmp_d       = tmp_q;
        sp_result_d = sp_result_q;
        w_mem_addr  = bus.if_addr;
        w_mem_we    = 1'b0;
        w_wdata     = '0;
        w_if_valid  = 1'b0;
        w_stall     = 1'b0;
        w_freeze    = 1'b0;
        w_flush     = 1'b0;
        w_done      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.sp_op != c_OP_NONE) begin
                    // First access: fetch the pointer/operand at the base address.
                    w_mem_addr = bus.sp_addr;
                    tmp_d      = bus.mem_rdata;
                    w_stall    = 1'b1;
                    w_freeze   = 1'b1;
                    state_d    = S_SECOND;
                end else if (bus.dm_read || bus.dm_write) begin
                    w_mem_addr = bus.dm_addr;
                    w_mem_we   = bus.dm_write;
                    w_wdata    = bus.dm_wdata;
                    w_freeze   = 1'b1;
                    w_flush    = 1'b1;
                end else begin
                    w_if_valid = 1'b1;
                end
            end

            S_SECOND: begin
                w_stall  = 1'b1;
                w_freeze = 1'b1;
                state_d  = S_DONE;
                case (bus.sp_op)
                    c_OP_LWI: begin
                        w_mem_addr  = AW'(tmp_q);
                        sp_result_d = bus.mem_rdata;
                    end
                    c_OP_SWI: begin
                        w_mem_addr  = AW'(tmp_q);
                        w_mem_we    = 1'b1;
                        w_wdata     = bus.sp_wdata;
                        sp_result_d = tmp_q;
                    end
                    c_OP_ADD: begin
                        // Read-modify-write back to the base address.
                        w_mem_addr  = bus.sp_addr;
                        w_mem_we    = 1'b1;
                        w_wdata     = w_sum;
                        sp_result_d = w_sum;
                    end
                    default: ;
                endcase
            end

            S_DONE: begin
                // The finished op is still in MEM, so only fetch is served.
                w_if_valid = 1'b1;
                w_done     = 1'b1;
                state_d    = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase

        if (rest) begin
            w_mem_addr = bus.if_addr;
            w_mem_we   = 1'b0;
            w_wdata    = '0;
            w_if_valid = 1'b0;
            w_stall    = 1'b0;
            w_freeze   = 1'b0;
            w_flush    = 1'b0;
            w_done     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rest) begin
            state_q     <= S_IDLE;
            tmp_q       <= '0;
            sp_result_q <= '0;
        end else begin
            state_q     <= state_d;
            tmp_q       <= tmp_d;
            sp_result_q <= sp_result_d;
        end
    end

    assign bus.mem_addr   = w_mem_addr;
    assign bus.mem_we     = w_mem_we;
    assign bus.mem_wdata  = w_mem_we ? w_wdata : '0;
    assign bus.if_valid   = w_if_valid;
    assign bus.stall_pipe = w_stall;
    assign bus.freeze_pc  = w_freeze;
    assign bus.flush_ifid = w_flush;
    assign bus.sp_done    = w_done;
    assign bus.sp_result  = sp_result_q;

endmodule
`default_nettype wire
